// File: rtl/pixy_frame_ctrl.sv
// ---------------------------------------------------------------------------
// pixy_frame_ctrl
//
// Paces SPI byte reads from the Pixy camera and parses the returned byte
// stream into validated ball coordinates for the PID loop.
//
// Frame layout on the wire (all words little-endian, low byte first):
//   0x55 0xAA 0x55 0xAA  | cksum | sig | x | y | width | height
// After the double sync word, twelve FIELD bytes (indices 0-11) follow.
// A frame is accepted when the coordinates are in range and, when the
// checksum feature is built, the checksum matches the 16-bit sum of the
// five words after it.
//
// Optional feature macro: PIXY_CKSUM_EN
//   defined   - checksum accumulator built, checksum gates acceptance
//   undefined - checksum bytes consumed and ignored, range check only
//
// Ports:
//   clk        in   single rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   byte_in    in   received byte, valid while byte_valid is high
//   byte_valid in   one-cycle strobe from the SPI master
//   spi_busy   in   SPI master mid-transfer; delays the next byte_req
//   byte_req   out  one-cycle pulse starting one SPI byte transfer
//   x_center   out  last accepted x coordinate
//   y_center   out  last accepted y coordinate
//   new_vals   out  one-cycle pulse when x_center/y_center update
//   frame_err  out  one-cycle pulse on a rejected or aborted frame
//   err_count  out  rejected/aborted frame count, saturating at 255
// ---------------------------------------------------------------------------
module pixy_frame_ctrl #(
  parameter int POLL_DIV = 50,
  parameter int TIMEOUT  = 1000,
  parameter int X_MAX    = 319,
  parameter int Y_MAX    = 199
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        spi_busy,
  output logic        byte_req,
  output logic [15:0] x_center,
  output logic [15:0] y_center,
  output logic        new_vals,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int PW = $clog2(POLL_DIV);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT - 1);
  localparam logic [15:0]   X_LIM     = 16'(X_MAX);
  localparam logic [15:0]   Y_LIM     = 16'(Y_MAX);

  localparam logic [7:0] SYNC_LO = 8'h55;
  localparam logic [7:0] SYNC_HI = 8'hAA;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    S1H   = 3'd1,
    S2L   = 3'd2,
    S2H   = 3'd3,
    FIELD = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0] poll_cnt;
  logic [WW-1:0] wd_cnt;
  logic          wd_expire;

  logic [3:0]  idx, idx_nxt;
  logic [7:0]  lo_byte, lo_byte_nxt;
  logic [15:0] x_cand, x_cand_nxt;
  logic [15:0] y_cand, y_cand_nxt;
  logic [15:0] x_nxt, y_nxt;
  logic        new_vals_nxt, frame_err_nxt, err_inc;
  logic [15:0] word;
  logic        cksum_ok;
  logic        frame_ok;

  // The current word is the incoming high byte joined with the low byte
  // latched on the previous FIELD strobe.
  assign word = {byte_in, lo_byte};

  // Watchdog only fires when no byte arrives this cycle, so a byte landing
  // on the expiry cycle is processed normally instead of aborting.
  assign wd_expire = (state != HUNT) && !byte_valid && (wd_cnt == WD_LAST);

  // Poller: free-running divider that requests one SPI byte per period.
  // At terminal count it waits for the SPI master to go idle, then fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_cnt <= '0;
      byte_req <= 1'b0;
    end else begin
      byte_req <= 1'b0;
      if (poll_cnt == POLL_LAST) begin
        if (!spi_busy) begin
          byte_req <= 1'b1;
          poll_cnt <= '0;
        end
      end else begin
        poll_cnt <= poll_cnt + PW'(1);
      end
    end
  end

  // Watchdog: counts idle cycles while a frame is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == HUNT || byte_valid || wd_expire) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WW'(1);
    end
  end

`ifdef PIXY_CKSUM_EN
  logic [15:0] acc, acc_nxt;
  logic [15:0] cksum_rx, cksum_rx_nxt;
  logic [15:0] sum_final;

  // Checksum path: latch the received checksum (word at index 1) and add
  // each following word when its high byte arrives. The height word is
  // added combinationally so the decision is made on the index-11 edge.
  always_comb begin
    acc_nxt      = acc;
    cksum_rx_nxt = cksum_rx;
    sum_final    = acc + word;
    if (state != FIELD) begin
      acc_nxt = '0;
    end else if (byte_valid) begin
      if (idx == 4'd1) begin
        cksum_rx_nxt = word;
      end else if (idx[0] && idx != 4'd11) begin
        acc_nxt = acc + word;
      end
    end
    cksum_ok = (sum_final == cksum_rx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cksum_rx <= '0;
    end else begin
      acc      <= acc_nxt;
      cksum_rx <= cksum_rx_nxt;
    end
  end
`else
  assign cksum_ok = 1'b1;
`endif

  assign frame_ok = cksum_ok && (x_cand <= X_LIM) && (y_cand <= Y_LIM);

  // Next-state and datapath decode. Sync-word mismatches simply fall back
  // to HUNT without flagging an error; only completed-but-bad frames and
  // watchdog aborts count as errors.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    lo_byte_nxt   = lo_byte;
    x_cand_nxt    = x_cand;
    y_cand_nxt    = y_cand;
    x_nxt         = x_center;
    y_nxt         = y_center;
    new_vals_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    err_inc       = 1'b0;

    if (byte_valid) begin
      case (state)
        HUNT: begin
          if (byte_in == SYNC_LO) state_nxt = S1H;
        end
        S1H: begin
          if (byte_in == SYNC_HI)      state_nxt = S2L;
          else if (byte_in == SYNC_LO) state_nxt = S1H;
          else                         state_nxt = HUNT;
        end
        S2L: begin
          state_nxt = (byte_in == SYNC_LO) ? S2H : HUNT;
        end
        S2H: begin
          if (byte_in == SYNC_HI) begin
            state_nxt = FIELD;
            idx_nxt   = '0;
          end else begin
            state_nxt = HUNT;
          end
        end
        FIELD: begin
          lo_byte_nxt = byte_in;
          idx_nxt     = idx + 4'd1;
          case (idx)
            4'd5: x_cand_nxt = word;
            4'd7: y_cand_nxt = word;
            4'd11: begin
              state_nxt = HUNT;
              idx_nxt   = '0;
              if (frame_ok) begin
                x_nxt        = x_cand;
                y_nxt        = y_cand;
                new_vals_nxt = 1'b1;
              end else begin
                frame_err_nxt = 1'b1;
                err_inc       = 1'b1;
              end
            end
            default: ;
          endcase
        end
        default: state_nxt = HUNT;
      endcase
    end else if (wd_expire) begin
      state_nxt     = HUNT;
      idx_nxt       = '0;
      frame_err_nxt = 1'b1;
      err_inc       = 1'b1;
    end
  end

  // State, frame-capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      idx       <= '0;
      lo_byte   <= '0;
      x_cand    <= '0;
      y_cand    <= '0;
      x_center  <= '0;
      y_center  <= '0;
      new_vals  <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      lo_byte   <= lo_byte_nxt;
      x_cand    <= x_cand_nxt;
      y_cand    <= y_cand_nxt;
      x_center  <= x_nxt;
      y_center  <= y_nxt;
      new_vals  <= new_vals_nxt;
      frame_err <= frame_err_nxt;
      if (err_inc && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/pixy_frame_ctrl.md
# pixy_frame_ctrl

Clocked controller that paces byte reads from the Pixy camera link and parses the resulting byte stream into validated ball coordinates. It sits between the SPI byte master, which it drives through `byte_req`/`spi_busy`, and the PID loop, which consumes `x_center`/`y_center` on the `new_vals` pulse. It hunts for the Pixy double sync word, collects one object block, checks the checksum and coordinate range, and recovers from stalled or corrupt frames with a watchdog.

## Interface
- `POLL_DIV`, 50: clock cycles between byte requests; legal range ≥ 4.
- `TIMEOUT`, 1000: cycles with no `byte_valid` while mid-frame before abort.
- `X_MAX`, 319: largest accepted x coordinate.
- `Y_MAX`, 199: largest accepted y coordinate.
- `clk` in 1: the only clock; all logic runs on its rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `byte_in` in 8: received byte; sampled only when `byte_valid` is high.
- `byte_valid` in 1: one-cycle strobe from the SPI master, marking `byte_in` valid.
- `spi_busy` in 1: SPI master is mid-transfer.
- `byte_req` out 1: one-cycle pulse that starts one SPI byte transfer.
- `x_center` out 16: last accepted x.
- `y_center` out 16: last accepted y.
- `new_vals` out 1: one-cycle pulse when `x_center`/`y_center` update.
- `frame_err` out 1: one-cycle pulse on a rejected or aborted frame.
- `err_count` out 8: rejected/aborted frames; saturates at 255.

## Operation
- Reset values: all outputs 0; state HUNT; poll, watchdog, byte index and checksum accumulator all 0.
- Byte order: Pixy words are little-endian, low byte first. Sync word is 0xAA55, so the wire order is 0x55 then 0xAA.
- State machine; transitions occur only on `byte_valid`, except the watchdog abort.
- HUNT:
  - 0x55 → S1H.
  - Any other byte → stay in HUNT.
- S1H:
  - 0xAA → S2L.
  - 0x55 → stay in S1H.
  - Any other byte → HUNT.
- S2L:
  - 0x55 → S2H.
  - Any other byte → HUNT.
- S2H:
  - 0xAA → FIELD, with index 0 and accumulator 0.
  - Any other byte → HUNT.
- FIELD: 12 bytes, indices 0–11.
  - 0–1: checksum.
  - 2–3: signature.
  - 4–5: x.
  - 6–7: y.
  - 8–9: width.
  - 10–11: height.
- Checksum rule: 16-bit sum, modulo 2^16, of the five words at indices 2–11. Each word is added to the accumulator when its high byte arrives.
- On index 11 the final word is summed combinationally with the accumulator. The frame is accepted if checksum matches, x ≤ `X_MAX` and y ≤ `Y_MAX`.
  - Accept: update `x_center`/`y_center` and pulse `new_vals`.
  - Reject: leave the outputs unchanged, pulse `frame_err` and increment `err_count`.
  - Either way → HUNT.
- Range-check comparisons are unsigned, 16-bit.
- Poller:
  - The counter increments every cycle.
  - At `POLL_DIV-1`, with `spi_busy` low, it pulses `byte_req` and clears.
  - If `spi_busy` is high at terminal count, it holds at terminal count and fires the first cycle `spi_busy` is low.
- Watchdog:
  - Cleared by every `byte_valid` and while in HUNT.
  - Outside HUNT, reaching `TIMEOUT` → HUNT, `frame_err` pulse, `err_count` increment.
  - If `byte_valid` arrives in the same cycle the watchdog expires, the byte wins: it is processed and the watchdog clears.
- A sync mismatch in S1H/S2L/S2H is not an error; it does not count and does not pulse `frame_err`.
- `rst_n` asserted mid-frame: immediate return to reset values. The partially collected frame is discarded, and `x_center`/`y_center` return to 0.

## Timing
- `new_vals`, `frame_err` and the updated coordinates all become visible in the cycle after the edge that samples byte index 11. Latency from the final byte is 1 cycle.
- `new_vals` and `frame_err` are each high for exactly one cycle and are never high together.
- `byte_req` is high for 1 cycle. Consecutive `byte_req` pulses are at least `POLL_DIV` cycles apart.
- The block accepts back-to-back `byte_valid` strobes, one per cycle, without loss.

## Configuration
- `PIXY_CKSUM_EN` defined:
  - The checksum comparison is part of the accept condition.
  - The accumulator is built.
- `PIXY_CKSUM_EN` undefined:
  - The accumulator is removed, and bytes 0–1 are consumed and ignored.
  - Acceptance depends on the range check only.
  - Framing, watchdog and poller behaviour are unchanged.

## Test plan
- Reset released, `spi_busy`=0 → `byte_req` pulses at cycles 50, 100, 150, …; all outputs 0.
- Bytes 55 AA 55 AA, checksum 0x00C8, sig 0x0001, x 0x00A0, y 0x0020, w 0x0005, h 0x0002 (sum 0x00C8) → `new_vals` for 1 cycle; `x_center`=160, `y_center`=32.
- Same frame with checksum 0x00C9 → `frame_err` pulse; `err_count`=1; coordinates keep their prior values. With `PIXY_CKSUM_EN` undefined → accepted instead.
- Valid checksum, x=0x0140 (320) → rejected, `err_count` increments.
- Stream 00 55 55 AA 12 → returns to HUNT with no error. Separately, a frame stalled after 6 FIELD bytes for 1000 cycles → `frame_err`, HUNT.
- `spi_busy` held high across the terminal count for 20 cycles → no `byte_req` until `spi_busy` falls; exactly one pulse in the first low cycle. `rst_n` low mid-FIELD → outputs 0, next frame parses normally.
